// File: rtl/mult_pkg.sv
// Shared types and helpers for the pipelined multiply-accumulate block.
package mult_pkg;

  // Per-beat control that must travel alongside its product.
  typedef struct packed {
    logic valid;
    logic acc_clr;
    logic acc_en;
    logic signed_p;
  } beat_flags_t;

  function automatic logic acc_width_ok(input int unsigned wa, input int unsigned wb,
                                        input int unsigned wacc, input int unsigned stages);
    return (wa >= 2) && (wb >= 2) && (wacc >= wa + wb) && (stages >= 1);
  endfunction

  // Signed: addends share a sign the sum does not; unsigned: carry out of the MSB.
  function automatic logic acc_overflow(input logic is_signed, input logic a_msb,
                                        input logic b_msb, input logic s_msb,
                                        input logic carry);
    return is_signed ? ((a_msb == b_msb) && (s_msb != a_msb)) : carry;
  endfunction

endpackage

// File: rtl/mult_pipe_dly.sv
// Clock-enabled delay line of DEPTH registers with asynchronous reset.
module mult_pipe_dly #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             ce_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    logic [WIDTH-1:0] stage_d;
    logic [WIDTH-1:0] stage_q;

    if (g == 0) begin : g_head
      assign stage_d = d_i;
    end else begin : g_link
      assign stage_d = g_stage[g-1].stage_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        stage_q <= '0;
      end else if (ce_i) begin
        stage_q <= stage_d;
      end
    end
  end

  assign q_o = g_stage[DEPTH-1].stage_q;

endmodule

// File: rtl/mult_acc_pipe.sv
// Pipelined multiply-accumulate: input register, product delay line, accumulator
// with per-beat signedness, accumulate/clear control and sticky overflow.
module mult_acc_pipe
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH_A     = 18,
  parameter int unsigned WIDTH_B     = 18,
  parameter int unsigned ACC_WIDTH   = 48,
  parameter int unsigned PIPE_STAGES = 1
) (
  input  logic                 CLK0,
  input  logic                 RST0,
  input  logic                 CE,
  input  logic                 IN_VALID,
  input  logic [WIDTH_A-1:0]   A,
  input  logic [WIDTH_B-1:0]   B,
  input  logic                 SIGNEDA,
  input  logic                 SIGNEDB,
  input  logic                 ACC_EN,
  input  logic                 ACC_CLR,
  output logic                 OUT_VALID,
  output logic [ACC_WIDTH-1:0] P,
  output logic                 SIGNEDP,
  output logic                 OVF
);

  localparam int unsigned PROD_W = WIDTH_A + WIDTH_B;
  localparam int unsigned FLAG_W = $bits(beat_flags_t);
  localparam int unsigned DLY_W  = PROD_W + FLAG_W;

  if (!acc_width_ok(WIDTH_A, WIDTH_B, ACC_WIDTH, PIPE_STAGES)) begin : g_param_check
    $error("mult_acc_pipe: illegal width/stage parameters");
  end

  logic [WIDTH_A-1:0] a_q;
  logic [WIDTH_B-1:0] b_q;
  logic               sa_q;
  logic               sb_q;
  beat_flags_t        flags0_q;

  always_ff @(posedge CLK0 or posedge RST0) begin
    if (RST0) begin
      a_q      <= '0;
      b_q      <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      flags0_q <= '0;
    end else if (CE) begin
      a_q      <= A;
      b_q      <= B;
      sa_q     <= SIGNEDA;
      sb_q     <= SIGNEDB;
      flags0_q <= '{valid: IN_VALID, acc_clr: ACC_CLR, acc_en: ACC_EN,
                    signed_p: SIGNEDA | SIGNEDB};
    end
  end

  // One extra bit per operand makes a single signed multiply cover every sign mix.
  logic signed [WIDTH_A:0] a_ext_c;
  logic signed [WIDTH_B:0] b_ext_c;
  logic [PROD_W-1:0]       prod_c;

  assign a_ext_c = {sa_q & a_q[WIDTH_A-1], a_q};
  assign b_ext_c = {sb_q & b_q[WIDTH_B-1], b_q};
  assign prod_c  = PROD_W'(a_ext_c) * PROD_W'(b_ext_c);

  logic [PROD_W-1:0] prod_p;
  beat_flags_t       flags_p;

  mult_pipe_dly #(
    .WIDTH (DLY_W),
    .DEPTH (PIPE_STAGES)
  ) u_dly (
    .clk_i (CLK0),
    .rst_i (RST0),
    .ce_i  (CE),
    .d_i   ({prod_c, flags0_q}),
    .q_o   ({prod_p, flags_p})
  );

  logic [ACC_WIDTH-1:0] p_q, p_d;
  logic                 ovf_q, ovf_d;
  logic                 sp_q, sp_d;
  logic                 ov_q, ov_d;
  logic [ACC_WIDTH-1:0] ext_c;
  logic [ACC_WIDTH:0]   sum_c;
  logic                 add_ovf_c;

  assign ext_c     = flags_p.signed_p ? ACC_WIDTH'($signed(prod_p)) : ACC_WIDTH'(prod_p);
  assign sum_c     = {1'b0, p_q} + {1'b0, ext_c};
  assign add_ovf_c = acc_overflow(flags_p.signed_p, p_q[ACC_WIDTH-1], ext_c[ACC_WIDTH-1],
                                  sum_c[ACC_WIDTH-1], sum_c[ACC_WIDTH]);

  always_comb begin
    p_d   = p_q;
    ovf_d = ovf_q;
    sp_d  = sp_q;
    ov_d  = 1'b0;
    if (flags_p.valid) begin
      ov_d = 1'b1;
      sp_d = flags_p.signed_p;
      if (flags_p.acc_clr) begin
        p_d   = ext_c;
        ovf_d = 1'b0;
      end else if (flags_p.acc_en) begin
        p_d   = sum_c[ACC_WIDTH-1:0];
        ovf_d = ovf_q | add_ovf_c;
      end else begin
        p_d = ext_c;
      end
    end
  end

  always_ff @(posedge CLK0 or posedge RST0) begin
    if (RST0) begin
      p_q   <= '0;
      ovf_q <= 1'b0;
      sp_q  <= 1'b0;
      ov_q  <= 1'b0;
    end else if (CE) begin
      p_q   <= p_d;
      ovf_q <= ovf_d;
      sp_q  <= sp_d;
      ov_q  <= ov_d;
    end
  end

  assign P         = p_q;
  assign OVF       = ovf_q;
  assign SIGNEDP   = sp_q;
  assign OUT_VALID = ov_q;

endmodule

// File: tb/tb_mult_acc_pipe.sv
// Self-checking bench for mult_acc_pipe: default 48-bit and a 36-bit accumulator
// instance share stimulus and are checked against an integer arithmetic model.
module tb_mult_acc_pipe;

  // Enabled edges from input capture to result register (PIPE_STAGES + 1).
  localparam int LAT = 2;

  logic        CLK0 = 1'b0;
  logic        RST0, CE, IN_VALID, SIGNEDA, SIGNEDB, ACC_EN, ACC_CLR;
  logic [17:0] A, B;
  logic        OUT_VALID, SIGNEDP, OVF;
  logic [47:0] P;
  logic        ov36, sp36, ovf36;
  logic [35:0] p36;

  always #5 CLK0 = ~CLK0;

  mult_acc_pipe dut (
    .CLK0(CLK0), .RST0(RST0), .CE(CE), .IN_VALID(IN_VALID), .A(A), .B(B),
    .SIGNEDA(SIGNEDA), .SIGNEDB(SIGNEDB), .ACC_EN(ACC_EN), .ACC_CLR(ACC_CLR),
    .OUT_VALID(OUT_VALID), .P(P), .SIGNEDP(SIGNEDP), .OVF(OVF)
  );

  mult_acc_pipe #(.ACC_WIDTH(36)) dut36 (
    .CLK0(CLK0), .RST0(RST0), .CE(CE), .IN_VALID(IN_VALID), .A(A), .B(B),
    .SIGNEDA(SIGNEDA), .SIGNEDB(SIGNEDB), .ACC_EN(ACC_EN), .ACC_CLR(ACC_CLR),
    .OUT_VALID(ov36), .P(p36), .SIGNEDP(sp36), .OVF(ovf36)
  );

  typedef struct {
    logic [17:0] a, b;
    bit          sa, sb, en, clr;
    int          due;
  } beat_t;

  int     checks = 0;
  int     failures = 0;
  int     edge_cnt = 0;
  beat_t  pend[$];
  longint m_p48, m_p36;
  bit     m_ovf48, m_ovf36, m_sp, e_v;

  // Result of one accepted beat on a w-bit accumulator, from plain integer arithmetic.
  function automatic void acc_next(input int w, input longint p_old, input bit ovf_old,
                                   input beat_t bt, output longint p_new, output bit ovf_new);
    longint av, bv, mask, half, ext, ps, es;
    bit     o;
    av   = (bt.sa && bt.a[17]) ? longint'(bt.a) - 262144 : longint'(bt.a);
    bv   = (bt.sb && bt.b[17]) ? longint'(bt.b) - 262144 : longint'(bt.b);
    mask = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    ext  = (av * bv) & mask;
    if (bt.sa || bt.sb) begin
      ps = (p_old >= half) ? p_old - (mask + 1) : p_old;
      es = (ext >= half) ? ext - (mask + 1) : ext;
      o  = (ps + es >= half) || (ps + es < -half);
    end else begin
      o = (p_old + ext) > mask;
    end
    if (bt.clr) begin
      p_new = ext; ovf_new = 1'b0;
    end else if (bt.en) begin
      p_new = (p_old + ext) & mask; ovf_new = ovf_old | o;
    end else begin
      p_new = ext; ovf_new = ovf_old;
    end
  endfunction

  task automatic model_reset();
    pend.delete();
    m_p48 = 0; m_p36 = 0; m_ovf48 = 0; m_ovf36 = 0; m_sp = 0; e_v = 0;
  endtask

  // Drive one cycle at the falling edge and advance the model at the rising edge.
  task automatic cycle(input bit ce, input bit v, input logic [17:0] a, input logic [17:0] b,
                       input bit sa, input bit sb, input bit en, input bit clr);
    beat_t bt;
    @(negedge CLK0);
    CE = ce; IN_VALID = v; A = a; B = b;
    SIGNEDA = sa; SIGNEDB = sb; ACC_EN = en; ACC_CLR = clr;
    @(posedge CLK0);
    if (ce) begin
      edge_cnt++;
      e_v = 1'b0;
      if (pend.size() != 0 && pend[0].due == edge_cnt) begin
        bt = pend.pop_front();
        acc_next(48, m_p48, m_ovf48, bt, m_p48, m_ovf48);
        acc_next(36, m_p36, m_ovf36, bt, m_p36, m_ovf36);
        m_sp = bt.sa | bt.sb;
        e_v  = 1'b1;
      end
      if (v) begin
        bt = '{a: a, b: b, sa: sa, sb: sb, en: en, clr: clr, due: edge_cnt + LAT};
        pend.push_back(bt);
      end
    end
    #1;
  endtask

  task automatic test_reset();
    CE = 0; IN_VALID = 0; A = '0; B = '0; SIGNEDA = 0; SIGNEDB = 0; ACC_EN = 0; ACC_CLR = 0;
    RST0 = 0;
    #2 RST0 = 1;
    #1;
    checks++;
    if ({OUT_VALID, SIGNEDP, OVF, P, ov36, sp36, ovf36, p36} !== 88'd0) begin
      failures++;
      $display("FAIL reset: got v=%b sp=%b ovf=%b p=%h p36=%h, want all zero",
               OUT_VALID, SIGNEDP, OVF, P, p36);
    end
    repeat (2) @(negedge CLK0);
    RST0 = 0;
    model_reset();
  endtask

  task automatic test_directed();
    logic [17:0] ta [3];
    logic [17:0] tb [3];
    bit          tsa [3];
    bit          tsb [3];
    logic [47:0] lit_p [3];
    bit          lit_sp [3];
    ta[0] = 18'h20000; tb[0] = 18'h20000; tsa[0] = 1; tsb[0] = 1;
    ta[1] = 18'h3FFFF; tb[1] = 18'h3FFFF; tsa[1] = 0; tsb[1] = 0;
    ta[2] = 18'h3FFFF; tb[2] = 18'h00002; tsa[2] = 1; tsb[2] = 0;
    lit_p[0] = 48'h0004_0000_0000; lit_sp[0] = 1;
    lit_p[1] = 48'h000F_FFF8_0001; lit_sp[1] = 0;
    lit_p[2] = 48'hFFFF_FFFF_FFFE; lit_sp[2] = 1;
    for (int i = 0; i < 6; i++) begin
      if (i < 3) cycle(1, 1, ta[i], tb[i], tsa[i], tsb[i], 0, 0);
      else       cycle(1, 0, 18'($urandom), 18'($urandom), 0, 0, 0, 0);
      checks++;
      if ({OUT_VALID, SIGNEDP, OVF, P} !== {e_v, m_sp, m_ovf48, 48'(m_p48)} ||
          {ov36, sp36, ovf36, p36} !== {e_v, m_sp, m_ovf36, 36'(m_p36)}) begin
        failures++;
        $display("FAIL directed model cyc %0d: got v=%b sp=%b ovf=%b p=%h p36=%h, want v=%b sp=%b ovf=%b p=%h p36=%h",
                 i, OUT_VALID, SIGNEDP, OVF, P, p36, e_v, m_sp, m_ovf48, 48'(m_p48), 36'(m_p36));
      end
      checks++;
      if (i >= 2 && i < 5) begin
        if (OUT_VALID !== 1'b1 || P !== lit_p[i-2] || SIGNEDP !== lit_sp[i-2]) begin
          failures++;
          $display("FAIL directed literal cyc %0d: got v=%b p=%h sp=%b, want v=1 p=%h sp=%b",
                   i, OUT_VALID, P, SIGNEDP, lit_p[i-2], lit_sp[i-2]);
        end
      end else if (OUT_VALID !== 1'b0) begin
        failures++;
        $display("FAIL directed latency cyc %0d: got v=%b, want v=0", i, OUT_VALID);
      end
    end
  endtask

  task automatic test_accumulate();
    logic [47:0] lit_p [3];
    lit_p[0] = 48'd6; lit_p[1] = 48'd12; lit_p[2] = 48'd18;
    for (int i = 0; i < 6; i++) begin
      if (i < 3) cycle(1, 1, 18'd2, 18'd3, 0, 0, i != 0, i == 0);
      else       cycle(1, 0, 18'd0, 18'd0, 0, 0, 0, 0);
      checks++;
      if ({OUT_VALID, SIGNEDP, OVF, P} !== {e_v, m_sp, m_ovf48, 48'(m_p48)} ||
          {ov36, sp36, ovf36, p36} !== {e_v, m_sp, m_ovf36, 36'(m_p36)}) begin
        failures++;
        $display("FAIL accumulate model cyc %0d: got v=%b ovf=%b p=%h p36=%h, want v=%b ovf=%b p=%h p36=%h",
                 i, OUT_VALID, OVF, P, p36, e_v, m_ovf48, 48'(m_p48), 36'(m_p36));
      end
      if (i >= 2 && i < 5) begin
        checks++;
        if (OUT_VALID !== 1'b1 || P !== lit_p[i-2] || OVF !== 1'b0) begin
          failures++;
          $display("FAIL accumulate literal cyc %0d: got v=%b p=%0d ovf=%b, want v=1 p=%0d ovf=0",
                   i, OUT_VALID, P, OVF, lit_p[i-2]);
        end
      end
    end
  endtask

  task automatic test_overflow();
    bit lit_ovf [4];
    lit_ovf[0] = 0; lit_ovf[1] = 0; lit_ovf[2] = 1; lit_ovf[3] = 0;
    for (int i = 0; i < 7; i++) begin
      if (i < 4) cycle(1, 1, 18'h1FFFF, 18'h1FFFF, 1, 1, i == 1 || i == 2, i == 0 || i == 3);
      else       cycle(1, 0, 18'd0, 18'd0, 0, 0, 0, 0);
      checks++;
      if ({OUT_VALID, SIGNEDP, OVF, P} !== {e_v, m_sp, m_ovf48, 48'(m_p48)} ||
          {ov36, sp36, ovf36, p36} !== {e_v, m_sp, m_ovf36, 36'(m_p36)}) begin
        failures++;
        $display("FAIL overflow model cyc %0d: got ovf=%b p=%h ovf36=%b p36=%h, want ovf=%b p=%h ovf36=%b p36=%h",
                 i, OVF, P, ovf36, p36, m_ovf48, 48'(m_p48), m_ovf36, 36'(m_p36));
      end
      if (i >= 2 && i < 6) begin
        checks++;
        if (ov36 !== 1'b1 || ovf36 !== lit_ovf[i-2] || OVF !== 1'b0) begin
          failures++;
          $display("FAIL overflow literal cyc %0d: got v36=%b ovf36=%b ovf48=%b, want v36=1 ovf36=%b ovf48=0",
                   i, ov36, ovf36, OVF, lit_ovf[i-2]);
        end
      end
    end
  endtask

  task automatic test_random_stall();
    bit ce, v;
    for (int i = 0; i < 46; i++) begin
      ce = !(i >= 15 && i < 19);
      v  = (i < 40) && ($urandom_range(0, 3) != 0);
      cycle(ce, v, 18'($urandom), 18'($urandom), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0);
      checks++;
      if ({OUT_VALID, SIGNEDP, OVF, P} !== {e_v, m_sp, m_ovf48, 48'(m_p48)} ||
          {ov36, sp36, ovf36, p36} !== {e_v, m_sp, m_ovf36, 36'(m_p36)}) begin
        failures++;
        $display("FAIL random cyc %0d ce=%b: got v=%b sp=%b ovf=%b p=%h ovf36=%b p36=%h, want v=%b sp=%b ovf=%b p=%h ovf36=%b p36=%h",
                 i, ce, OUT_VALID, SIGNEDP, OVF, P, ovf36, p36,
                 e_v, m_sp, m_ovf48, 48'(m_p48), m_ovf36, 36'(m_p36));
      end
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) cycle(1, 1, 18'd1234, 18'd77, 0, 0, i != 0, i == 0);
    @(negedge CLK0);
    IN_VALID = 0;
    #2 RST0 = 1;
    #1;
    checks++;
    if ({OUT_VALID, OVF, P, ov36, ovf36, p36} !== 86'd0) begin
      failures++;
      $display("FAIL async reset: got v=%b ovf=%b p=%h p36=%h, want all zero before edge",
               OUT_VALID, OVF, P, p36);
    end
    @(negedge CLK0);
    RST0 = 0;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      if (i == 0) cycle(1, 1, 18'd3, 18'd5, 0, 0, 1, 0);
      else        cycle(1, 0, 18'd0, 18'd0, 0, 0, 0, 0);
      checks++;
      if ({OUT_VALID, SIGNEDP, OVF, P} !== {e_v, m_sp, m_ovf48, 48'(m_p48)} ||
          {ov36, sp36, ovf36, p36} !== {e_v, m_sp, m_ovf36, 36'(m_p36)}) begin
        failures++;
        $display("FAIL post-reset model cyc %0d: got v=%b p=%h p36=%h, want v=%b p=%h p36=%h",
                 i, OUT_VALID, P, p36, e_v, 48'(m_p48), 36'(m_p36));
      end
      if (i == 2) begin
        checks++;
        if (OUT_VALID !== 1'b1 || P !== 48'd15 || OVF !== 1'b0) begin
          failures++;
          $display("FAIL post-reset literal: got v=%b p=%0d ovf=%b, want v=1 p=15 ovf=0",
                   OUT_VALID, P, OVF);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_accumulate();
    test_overflow();
    test_random_stall();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
